// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency sweep controller.
//   sweep_state_t   : FSM state encoding (also exported on the debug port)
//   DEF_PHASE_WIDTH : default width of frequency words (matches DDS fre_word)
//   DEF_DWELL_WIDTH : default width of the dwell count
package sweep_pkg;

  localparam int DEF_PHASE_WIDTH = 32;
  localparam int DEF_DWELL_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/sweep_ctrl_if.sv
// Control/status bundle between a sweep requester and sweep_ctrl.
//   start, abort, mode, f_start, f_stop, f_step, dwell : requester -> controller
//   fre_word, busy, step_valid, done, state_dbg       : controller -> requester
//
// Handshake: start is a single-cycle request with no ready; it is taken only
// when the controller is IDLE and abort is low in the same cycle, otherwise it
// is dropped. step_valid qualifies fre_word for exactly one cycle, the first
// cycle a new value is driven. done is a one-cycle completion strobe for
// single sweeps. abort has priority over everything else.
interface sweep_ctrl_if
  import sweep_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) ();

  logic                   start;
  logic                   abort;
  logic                   mode;
  logic [PHASE_WIDTH-1:0] f_start;
  logic [PHASE_WIDTH-1:0] f_stop;
  logic [PHASE_WIDTH-1:0] f_step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [PHASE_WIDTH-1:0] fre_word;
  logic                   busy;
  logic                   step_valid;
  logic                   done;
  sweep_state_t           state_dbg;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell,
    input  fre_word, busy, step_valid, done, state_dbg
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell,
    output fre_word, busy, step_valid, done, state_dbg
  );

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter used to time how long each frequency is held.
//   clock    : rising-edge clock
//   rstn     : synchronous active-high reset, clears the count
//   load     : load load_val into the counter (overrides counting)
//   load_val : value to load
//   expire   : high for the single cycle in which the count equals 1
module dwell_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (rstn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // Count of 1 is the last cycle before the counter parks at zero.
  assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency sweep controller driving a DDS frequency word.
//   clock : rising-edge clock
//   rstn  : synchronous active-high reset
//   bus   : sweep_ctrl_if.slave (request inputs, fre_word/busy/step_valid/done
//           outputs, state_dbg exposes the FSM state)
//
// Timing: each frequency value occupies max(dwell,1) cycles. The first
// max(dwell,1)-1 of those are spent in DWELL (timed by dwell_timer); the last
// cycle is STEP, during which the next value is computed and loaded at the
// following edge, so STEP never adds an output cycle.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
  input  logic         clock,
  input  logic         rstn,
  sweep_ctrl_if.slave  bus
);

  sweep_state_t           state_q, state_d;
  logic [PHASE_WIDTH-1:0] fre_q, fre_d;
  logic                   sv_q, sv_d;
  logic                   last_q, last_d;     // current value is the final one of a lap
  logic [PHASE_WIDTH-1:0] f_start_q, f_start_d;
  logic [PHASE_WIDTH-1:0] f_stop_q, f_stop_d;
  logic [PHASE_WIDTH-1:0] f_step_q, f_step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   mode_q, mode_d;

  logic                   tmr_load;
  logic [DWELL_WIDTH-1:0] tmr_val;
  logic                   tmr_expire;
  logic [PHASE_WIDTH:0]   sum;                // one extra bit catches carry-out

  dwell_timer #(.WIDTH(DWELL_WIDTH)) u_dwell_timer (
    .clock    (clock),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clock) begin
    if (rstn) begin
      state_q   <= IDLE;
      fre_q     <= '0;
      sv_q      <= 1'b0;
      last_q    <= 1'b0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fre_q     <= fre_d;
      sv_q      <= sv_d;
      last_q    <= last_d;
      f_start_q <= f_start_d;
      f_stop_q  <= f_stop_d;
      f_step_q  <= f_step_d;
      dwell_q   <= dwell_d;
      mode_q    <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fre_d     = fre_q;
    sv_d      = 1'b0;
    last_d    = last_q;
    f_start_d = f_start_q;
    f_stop_d  = f_stop_q;
    f_step_d  = f_step_q;
    dwell_d   = dwell_q;
    mode_d    = mode_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    sum       = {1'b0, fre_q} + {1'b0, f_step_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          f_start_d = bus.f_start;
          f_stop_d  = bus.f_stop;
          f_step_d  = bus.f_step;
          dwell_d   = bus.dwell;
          mode_d    = bus.mode;
          fre_d     = bus.f_start;
          sv_d      = 1'b1;
          // An empty or backwards range, or a zero step, is a one-point sweep.
          last_d    = (bus.f_start >= bus.f_stop) || (bus.f_step == '0);
          tmr_load  = 1'b1;
          tmr_val   = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_WIDTH'(1);
          state_d   = (bus.dwell > DWELL_WIDTH'(1)) ? DWELL : STEP;
        end
      end

      DWELL: begin
        if (tmr_expire) begin
          state_d = STEP;
        end
      end

      STEP: begin
        if (last_q && !mode_q) begin
          // fre_word keeps the final value through DONE and IDLE.
          state_d = DONE;
        end else begin
          if (last_q) begin
            fre_d  = f_start_q;
            last_d = (f_start_q >= f_stop_q) || (f_step_q == '0);
          end else if (sum[PHASE_WIDTH] || (sum >= {1'b0, f_stop_q})) begin
            fre_d  = f_stop_q;
            last_d = 1'b1;
          end else begin
            fre_d  = sum[PHASE_WIDTH-1:0];
            last_d = 1'b0;
          end
          sv_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);
          state_d  = (dwell_q > DWELL_WIDTH'(1)) ? DWELL : STEP;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // abort beats start and any step in progress.
    if (bus.abort) begin
      state_d  = IDLE;
      fre_d    = '0;
      sv_d     = 1'b0;
      last_d   = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
  end

  assign bus.fre_word   = fre_q;
  assign bus.step_valid = sv_q;
  assign bus.busy       = (state_q == DWELL) || (state_q == STEP);
  assign bus.done       = (state_q == DONE);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_sweep_ctrl;
  import sweep_pkg::*;

  localparam int PW = 32;
  localparam int DW = 24;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rstn  = 1'b1;
  always #5 clock = ~clock;

  sweep_ctrl_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) bus ();

  sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_last = '0;
  bit            exp_done = 1'b0;
  int            exp_hold = 1;
  bit            run_active = 1'b0;
  int            run_len = 0;
  int            cur_hold = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the list of frequency values one lap of a sweep visits.
  function automatic int model_push(input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                                    input logic [PW-1:0] st);
    logic [PW:0]   s;
    logic [PW-1:0] v;
    int            n;
    bit            fin;
    v = fs;
    n = 1;
    exp_q.push_back(fs);
    exp_last = fs;
    fin = (fs >= fe) || (st == '0);
    while (!fin) begin
      s = {1'b0, v} + {1'b0, st};
      if (s >= {1'b0, fe}) begin
        v   = fe;
        fin = 1'b1;
      end else begin
        v = s[PW-1:0];
      end
      exp_q.push_back(v);
      exp_last = v;
      n++;
    end
    return n;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (bus.step_valid) begin
      if (run_active) check("hold_len", run_len, cur_hold);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL step_word: step_valid with word %0h, none expected", bus.fre_word);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        checks--;
        check("step_word", bus.fre_word, e);
      end
      check("step_busy", bus.busy, 1);
      run_active = 1'b1;
      run_len    = 1;
      cur_hold   = exp_hold;
    end else if (bus.done) begin
      if (run_active) check("hold_len_last", run_len, cur_hold);
      check("done_expected", exp_done, 1);
      check("done_drained", exp_q.size(), 0);
      check("done_busy", bus.busy, 0);
      exp_done   = 1'b0;
      run_active = 1'b0;
    end else if (bus.busy && run_active) begin
      run_len++;
    end else if (!bus.busy) begin
      run_active = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1 with the DUT idle; returns in cycle 1 of the sweep.
  task automatic start_sweep(input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                             input logic [PW-1:0] st, input logic [DW-1:0] dw,
                             input bit md, output int n);
    bus.f_start = fs;
    bus.f_stop  = fe;
    bus.f_step  = st;
    bus.dwell   = dw;
    bus.mode    = md;
    bus.start   = 1'b1;
    exp_hold    = (dw == '0) ? 1 : int'(dw);
    n = model_push(fs, fe, st);
    if (md) begin
      void'(model_push(fs, fe, st));
      void'(model_push(fs, fe, st));
    end
    exp_done = !md;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic scramble_inputs();
    bus.f_start = $urandom;
    bus.f_stop  = $urandom;
    bus.f_step  = $urandom;
    bus.dwell   = DW'($urandom);
    bus.mode    = 1'($urandom_range(0, 1));
    bus.start   = bus.busy && ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_until_done(input string name, input int exp_cycle,
                                input int budget, input bit scramble);
    int cyc;
    bit seen;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= budget) begin
      if (bus.done) begin
        seen = 1'b1;
        if (exp_cycle > 0) check({name, "_done_cycle"}, cyc, exp_cycle);
      end else begin
        if (scramble) scramble_inputs();
        @(posedge clock); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    check({name, "_done_seen"}, seen, 1);
    @(posedge clock); #1;
    check({name, "_idle_word"}, bus.fre_word, exp_last);
    check({name, "_idle_busy"}, bus.busy, 0);
    check({name, "_idle_done"}, bus.done, 0);
    check({name, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
    exp_done = 1'b0;
  endtask

  task automatic run_cycles(input int count, input bit scramble);
    for (int i = 0; i < count; i++) begin
      check("no_done_mode1", bus.done, 0);
      if (scramble) scramble_inputs();
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic abort_now(input string name);
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_word"}, bus.fre_word, 0);
    check({name, "_sv"}, bus.step_valid, 0);
    check({name, "_done"}, bus.done, 0);
    exp_q.delete();
    exp_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [PW-1:0] fs, fe, st;
    logic [DW-1:0] dw;
    bit md;

    bus.start = 0; bus.abort = 0; bus.mode = 0;
    bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;

    rstn = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_word", bus.fre_word, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sv", bus.step_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", bus.state_dbg, IDLE);
    rstn = 1'b0;
    @(posedge clock); #1;

    // 100..130 step 10 dwell 3: done in cycle 13
    start_sweep(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, n);
    check("basic_len", n, 4);
    run_until_done("basic", 13, 100, 1'b0);

    // ceiling clamps to 125; inputs scrambled mid-sweep must not matter
    start_sweep(32'd100, 32'd125, 32'd10, 24'd3, 1'b0, n);
    run_until_done("ceil", 13, 100, 1'b1);

    // carry-out near the top of the range clamps to f_stop
    start_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd2, 1'b0, n);
    run_until_done("no_wrap", 5, 50, 1'b0);

    // continuous mode: 100 again in cycle 13, never done
    start_sweep(32'd100, 32'd130, 32'd10, 24'd3, 1'b1, n);
    for (int c = 1; c < 24; c++) begin
      if (c == 13) begin
        check("wrap_word", bus.fre_word, 100);
        check("wrap_sv", bus.step_valid, 1);
      end
      check("no_done_cont", bus.done, 0);
      @(posedge clock); #1;
    end
    abort_now("cont_abort");

    // abort sampled at edge 5
    start_sweep(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, n);
    repeat (4) begin @(posedge clock); #1; end
    abort_now("abort5");

    // start and abort together: nothing starts
    bus.f_start = 32'd55; bus.f_stop = 32'd99; bus.f_step = 32'd4; bus.dwell = 24'd2;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("start_abort_busy", bus.busy, 0);
      check("start_abort_word", bus.fre_word, 0);
      @(posedge clock); #1;
    end

    // dwell 0 and step 0: one cycle, done in cycle 2
    start_sweep(32'd7, 32'd500, 32'd0, 24'd0, 1'b0, n);
    run_until_done("single", 2, 10, 1'b0);

    // backwards range: single point for one dwell
    start_sweep(32'd300, 32'd200, 32'd5, 24'd2, 1'b0, n);
    run_until_done("backward", 3, 10, 1'b0);

    // reset mid-sweep
    start_sweep(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, n);
    repeat (3) begin @(posedge clock); #1; end
    rstn = 1'b1;
    @(posedge clock); #1;
    rstn = 1'b0;
    check("mid_rst_word", bus.fre_word, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sv", bus.step_valid, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_state", bus.state_dbg, IDLE);
    exp_q.delete();
    exp_done = 1'b0;
    @(posedge clock); #1;

    // randomized sweeps
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        fs = 32'hFFFF_FF00 + PW'($urandom_range(0, 127));
        fe = 32'hFFFF_FFFF - PW'($urandom_range(0, 3));
        st = PW'($urandom_range(1, 100));
      end else begin
        fs = $urandom;
        fe = fs + PW'($urandom_range(0, 300));
        st = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(1, 60));
      end
      dw = DW'($urandom_range(0, 4));
      md = ($urandom_range(0, 3) == 0);
      start_sweep(fs, fe, st, dw, md, n);
      if (!md) begin
        run_until_done("rand", n * exp_hold + 1, n * exp_hold + 10, 1'b1);
      end else begin
        run_cycles(2 * n * exp_hold - 1, 1'b1);
        abort_now("rand_abort");
      end
      @(posedge clock); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter PHASE_WIDTH, default 32, width of all frequency words; matches the downstream DDS fre_word.
REQ-002 Parameter DWELL_WIDTH, default 24, width of the dwell-count input.
REQ-003 clock  in  1  single clock; all logic is rising-edge.
REQ-004 rstn  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 start  in  1  one-cycle pulse that begins a sweep.
REQ-006 abort  in  1  terminates any sweep in progress.
REQ-007 mode  in  1  0 = single sweep, 1 = continuous (restart at f_start).
REQ-008 f_start  in  PHASE_WIDTH  first frequency word.
REQ-009 f_stop  in  PHASE_WIDTH  last frequency word (inclusive ceiling).
REQ-010 f_step  in  PHASE_WIDTH  increment per step.
REQ-011 dwell  in  DWELL_WIDTH  cycles each frequency is held.
REQ-012 fre_word  out  PHASE_WIDTH  registered frequency word driving the DDS.
REQ-013 busy  out  1  high while a sweep is active.
REQ-014 step_valid  out  1  one-cycle pulse in the first cycle of each new fre_word value.
REQ-015 done  out  1  one-cycle pulse when a single sweep completes.

Function
REQ-016 FSM states: IDLE, DWELL, STEP, DONE; IDLE->DWELL on start; DWELL->STEP when dwell expires; STEP->DWELL (more steps) or DONE (last step, mode 0) or DWELL at f_start (last step, mode 1); DONE->IDLE after 1 cycle.
REQ-017 f_start, f_stop, f_step, dwell, mode are latched on the accepted start; later input changes do not affect the sweep in progress.
REQ-018 start accepted at edge N -> fre_word = f_start, busy = 1, step_valid = 1 in cycle N+1.
REQ-019 Each fre_word value is held exactly max(dwell,1) cycles; the STEP state consumes no extra output cycle (next value appears in the cycle after the last dwell cycle).
REQ-020 Next value = cur + f_step computed at PHASE_WIDTH+1 bits; if the sum >= f_stop or carries out, the next value is f_stop and that is the last step.
REQ-021 f_start >= f_stop or f_step == 0 -> a single point at f_start for one dwell, then end.
REQ-022 Mode 0 end: done = 1 and busy = 0 in the cycle after the final dwell; fre_word holds the final value in IDLE.
REQ-023 Mode 1: after the final dwell, fre_word returns to the latched f_start with step_valid = 1; done never pulses; busy stays 1.
REQ-024 start while busy is ignored.
REQ-025 abort in any state -> next cycle IDLE, busy = 0, fre_word = 0, done = 0, no step_valid.
REQ-026 abort and start in the same cycle -> abort wins; the sweep does not start.

Reset
REQ-027 rstn high at an edge -> IDLE, fre_word = 0, busy = 0, step_valid = 0, done = 0, dwell counter = 0, latched registers = 0.
REQ-028 Reset mid-sweep is identical to REQ-027; no pending start or step survives reset.

Structure
REQ-029 Shared package sweep_pkg holds the FSM state encoding and the default PHASE_WIDTH/DWELL_WIDTH constants.
REQ-030 One sub-module, dwell_timer: loadable down-counter with an expiry pulse, DWELL_WIDTH wide; all other logic stays in sweep_ctrl.

Verification
REQ-031 f_start=100, f_stop=130, f_step=10, dwell=3, mode 0, start at edge 0 -> fre_word 100 in cycles 1-3, 110 in 4-6, 120 in 7-9, 130 in 10-12; 4 step_valid pulses; done=1 and busy=0 in cycle 13.
REQ-032 Same setup with f_stop=125 -> sequence 100, 110, 120, 125; done in cycle 13.
REQ-033 f_start=0xFFFFFFF0, f_step=0x20, f_stop=0xFFFFFFFF, dwell=2 -> fre_word 0xFFFFFFF0 then 0xFFFFFFFF; no wrap to a small value.
REQ-034 mode 1 with the REQ-031 values -> after 130, fre_word returns to 100 in cycle 13 with step_valid; done never asserts.
REQ-035 abort at cycle 5 of the REQ-031 sweep -> cycle 6: busy=0, fre_word=0; start+abort together -> no sweep.
REQ-036 dwell=0, f_step=0 -> fre_word=f_start for 1 cycle, done in cycle 2; reset asserted mid-sweep -> all outputs 0 next cycle.
